// File: rtl/hit_pkg.sv
// hit_pkg: shared types, widths and small helpers for the hit judge.
//   judge_t     : 2-bit per-lane judgement code (none/perfect/good/miss)
//   SCORE_W     : score register width
//   COMBO_W     : combo / max-combo register width
//   judge_lane  : per-lane decision for one cycle
//   is_hit      : true for perfect or good
//   sat_score   : clamp a widened score sum to SCORE_W bits
//   sat_combo   : clamp a widened combo sum to COMBO_W bits
package hit_pkg;

    localparam int SCORE_W = 16;
    localparam int COMBO_W = 8;

    typedef enum logic [1:0] {
        JUDGE_NONE = 2'd0,
        JUDGE_PERF = 2'd1,
        JUDGE_GOOD = 2'd2,
        JUDGE_MISS = 2'd3
    } judge_t;

    // A press on a live, unconsumed note always wins over the step miss, so a
    // press landing in the step cycle is judged against the outgoing note.
    function automatic judge_t judge_lane(
        input logic pressed,
        input logic note,
        input logic used,
        input logic step,
        input logic in_win
    );
        judge_t res;
        res = JUDGE_NONE;
        if (pressed && note && !used) begin
            if (in_win) begin
                res = JUDGE_PERF;
            end else begin
                res = JUDGE_GOOD;
            end
        end else if (step && note && !used) begin
            res = JUDGE_MISS;
        end else begin
            res = JUDGE_NONE;
        end
        return res;
    endfunction

    function automatic logic is_hit(input judge_t j);
        return (j == JUDGE_PERF) || (j == JUDGE_GOOD);
    endfunction

    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W+1:0] sum);
        logic [SCORE_W-1:0] res;
        if (sum[SCORE_W+1:SCORE_W] != 2'b00) begin
            res = {SCORE_W{1'b1}};
        end else begin
            res = sum[SCORE_W-1:0];
        end
        return res;
    endfunction

    function automatic logic [COMBO_W-1:0] sat_combo(input logic [COMBO_W:0] sum);
        logic [COMBO_W-1:0] res;
        if (sum[COMBO_W]) begin
            res = {COMBO_W{1'b1}};
        end else begin
            res = sum[COMBO_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter and rising-edge pulse
// for one raw player button.
//   clk   : judge clock
//   rst   : synchronous active-high reset
//   raw   : raw button level, asynchronous to clk
//   press : one-cycle pulse when the debounced level rises
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    // Wide enough to hold DB_CYCLES-1 even when DB_CYCLES is 1.
    localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;

    // Synchronise, count consecutive disagreeing samples, flip and pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= '0;
            press_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (sync2_r != level_r) begin
                // The DB_CYCLES-th disagreeing sample flips the level.
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= '0;
                    press_r <= sync2_r;
                end else begin
                    cnt_r   <= cnt_r + CNT_ONE;
                    press_r <= 1'b0;
                end
            end else begin
                cnt_r   <= '0;
                press_r <= 1'b0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/hit_judge.sv
// hit_judge: judges debounced red/blue button presses against the scrolling
// note stream and keeps score, combo and max combo.
//   clk, rst          : divided clock shared with shift_load; sync active-high reset
//   note_R, note_B    : lane note columns, bit 0 sits on the hit line
//   offset            : sub-step scroll position 0..15
//   finish            : song over; freezes judging and scoring
//   btn_red, btn_blue : raw player buttons
//   judge_r, judge_b  : registered one-cycle lane results (none/perf/good/miss)
//   score             : saturating score
//   combo, max_combo  : saturating current combo and its running maximum
module hit_judge #(
    parameter int DB_CYCLES = 16,
    parameter int PERF_LO   = 6,
    parameter int PERF_HI   = 10,
    parameter int PERF_PTS  = 3,
    parameter int GOOD_PTS  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  note_R,
    input  logic [9:0]  note_B,
    input  logic [3:0]  offset,
    input  logic        finish,
    input  logic        btn_red,
    input  logic        btn_blue,
    output logic [1:0]  judge_r,
    output logic [1:0]  judge_b,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo
);

    import hit_pkg::*;

    localparam logic [SCORE_W-1:0] PERF_V = SCORE_W'(PERF_PTS);
    localparam logic [SCORE_W-1:0] GOOD_V = SCORE_W'(GOOD_PTS);

    logic               press_red_s;
    logic               press_blue_s;
    logic [3:0]         offset_q_r;
    logic               used_r_r;
    logic               used_b_r;
    judge_t             judge_r_r;
    judge_t             judge_b_r;
    logic [SCORE_W-1:0] score_r;
    logic [COMBO_W-1:0] combo_r;
    logic [COMBO_W-1:0] max_combo_r;

    int                 off_i_s;
    logic               step_s;
    logic               in_win_s;
    logic               act_s;
    judge_t             res_r_s;
    judge_t             res_b_s;
    logic [SCORE_W-1:0] pts_r_s;
    logic [SCORE_W-1:0] pts_b_s;
    logic [SCORE_W+1:0] score_sum_s;
    logic [1:0]         hits_s;
    logic               miss_s;
    logic [COMBO_W-1:0] combo_nx_s;
    logic [COMBO_W-1:0] max_nx_s;
    logic               unused_notes_s;

    // Only the hit-line column is judged; the upcoming columns are for display.
    assign unused_notes_s = ^{note_R[9:1], note_B[9:1]};

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_red (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_red),
        .press (press_red_s)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_blue (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_blue),
        .press (press_blue_s)
    );

    // Per-lane judgement, points and the combo/score next-state.
    always_comb begin
        off_i_s  = int'(offset);
        // Signed compare keeps a window starting at 0 free of constant-compare noise.
        in_win_s = (off_i_s >= PERF_LO) && (off_i_s <= PERF_HI);
        step_s   = (offset_q_r == 4'd15) && (offset == 4'd0);
        act_s    = !finish;

        res_r_s = judge_lane(press_red_s && act_s, note_R[0], used_r_r, step_s && act_s, in_win_s);
        res_b_s = judge_lane(press_blue_s && act_s, note_B[0], used_b_r, step_s && act_s, in_win_s);

        case (res_r_s)
            JUDGE_PERF: pts_r_s = PERF_V;
            JUDGE_GOOD: pts_r_s = GOOD_V;
            default:    pts_r_s = {SCORE_W{1'b0}};
        endcase

        case (res_b_s)
            JUDGE_PERF: pts_b_s = PERF_V;
            JUDGE_GOOD: pts_b_s = GOOD_V;
            default:    pts_b_s = {SCORE_W{1'b0}};
        endcase

        score_sum_s = {2'b00, score_r} + {2'b00, pts_r_s} + {2'b00, pts_b_s};
        hits_s      = {1'b0, is_hit(res_r_s)} + {1'b0, is_hit(res_b_s)};
        miss_s      = (res_r_s == JUDGE_MISS) || (res_b_s == JUDGE_MISS);

        // A miss breaks the chain, but hits in the same cycle start the new one.
        if (miss_s) begin
            combo_nx_s = COMBO_W'(hits_s);
        end else begin
            combo_nx_s = sat_combo({1'b0, combo_r} + (COMBO_W + 1)'(hits_s));
        end

        if (combo_nx_s > max_combo_r) begin
            max_nx_s = combo_nx_s;
        end else begin
            max_nx_s = max_combo_r;
        end
    end

    // Step tracking, consumed flags, registered results and scoring state.
    always_ff @(posedge clk) begin
        if (rst) begin
            offset_q_r  <= 4'd0;
            used_r_r    <= 1'b0;
            used_b_r    <= 1'b0;
            judge_r_r   <= JUDGE_NONE;
            judge_b_r   <= JUDGE_NONE;
            score_r     <= {SCORE_W{1'b0}};
            combo_r     <= {COMBO_W{1'b0}};
            max_combo_r <= {COMBO_W{1'b0}};
        end else begin
            offset_q_r <= offset;

            // A new note arrives on the hit line at every step.
            if (step_s) begin
                used_r_r <= 1'b0;
            end else if (is_hit(res_r_s)) begin
                used_r_r <= 1'b1;
            end else begin
                used_r_r <= used_r_r;
            end

            if (step_s) begin
                used_b_r <= 1'b0;
            end else if (is_hit(res_b_s)) begin
                used_b_r <= 1'b1;
            end else begin
                used_b_r <= used_b_r;
            end

            if (finish) begin
                judge_r_r   <= JUDGE_NONE;
                judge_b_r   <= JUDGE_NONE;
                score_r     <= score_r;
                combo_r     <= combo_r;
                max_combo_r <= max_combo_r;
            end else begin
                judge_r_r   <= res_r_s;
                judge_b_r   <= res_b_s;
                score_r     <= sat_score(score_sum_s);
                combo_r     <= combo_nx_s;
                max_combo_r <= max_nx_s;
            end
        end
    end

    assign judge_r   = judge_r_r;
    assign judge_b   = judge_b_r;
    assign score     = score_r;
    assign combo     = combo_r;
    assign max_combo = max_combo_r;

endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: scoreboard bench for hit_judge. Instance 0 uses the default
// window and points with DB_CYCLES = 4; instance 1 uses a window starting at
// offset 0 and a large perfect value so score saturation is reachable quickly.
module tb_hit_judge;

    typedef struct {
        int d;
        int cyc;
        int jr;
        int jb;
        int sc;
        int cb;
        int mx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  note_r_a  [2];
    logic [9:0]  note_b_a  [2];
    logic [3:0]  offset_a  [2];
    logic        finish_a  [2];
    logic        btn_red_a [2];
    logic        btn_blue_a[2];
    logic [1:0]  judge_r_a [2];
    logic [1:0]  judge_b_a [2];
    logic [15:0] score_a   [2];
    logic [7:0]  combo_a   [2];
    logic [7:0]  max_a     [2];

    int perf_lo [2] = '{6, 0};
    int perf_hi [2] = '{10, 10};
    int perf_pts[2] = '{3, 32767};
    int exp_score[2];
    int exp_combo[2];
    int exp_max  [2];

    exp_t sb_q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    hit_judge #(.DB_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .note_R    (note_r_a[0]),
        .note_B    (note_b_a[0]),
        .offset    (offset_a[0]),
        .finish    (finish_a[0]),
        .btn_red   (btn_red_a[0]),
        .btn_blue  (btn_blue_a[0]),
        .judge_r   (judge_r_a[0]),
        .judge_b   (judge_b_a[0]),
        .score     (score_a[0]),
        .combo     (combo_a[0]),
        .max_combo (max_a[0])
    );

    hit_judge #(.DB_CYCLES(4), .PERF_LO(0), .PERF_HI(10), .PERF_PTS(32767), .GOOD_PTS(1)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .note_R    (note_r_a[1]),
        .note_B    (note_b_a[1]),
        .offset    (offset_a[1]),
        .finish    (finish_a[1]),
        .btn_red   (btn_red_a[1]),
        .btn_blue  (btn_blue_a[1]),
        .judge_r   (judge_r_a[1]),
        .judge_b   (judge_b_a[1]),
        .score     (score_a[1]),
        .combo     (combo_a[1]),
        .max_combo (max_a[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int win_judge(input int d, input int off);
        return (off >= perf_lo[d] && off <= perf_hi[d]) ? 1 : 2;
    endfunction

    // Update the reference totals for one judged cycle and queue what the DUT must show.
    task automatic expect_event(input int d, input int dcyc, input int jr, input int jb);
        int   hits;
        int   pts;
        exp_t e;
        hits = 0;
        pts  = 0;
        if (jr == 1) begin hits++; pts += perf_pts[d]; end
        else if (jr == 2) begin hits++; pts += 1; end
        if (jb == 1) begin hits++; pts += perf_pts[d]; end
        else if (jb == 2) begin hits++; pts += 1; end
        exp_score[d] = (exp_score[d] + pts > 65535) ? 65535 : exp_score[d] + pts;
        if (jr == 3 || jb == 3) exp_combo[d] = hits;
        else exp_combo[d] = (exp_combo[d] + hits > 255) ? 255 : exp_combo[d] + hits;
        if (exp_combo[d] > exp_max[d]) exp_max[d] = exp_combo[d];
        e.d   = d;
        e.cyc = cyc + dcyc;
        e.jr  = jr;
        e.jb  = jb;
        e.sc  = exp_score[d];
        e.cb  = exp_combo[d];
        e.mx  = exp_max[d];
        sb_q.push_back(e);
    endtask

    // Clean press held long enough to debounce, then released and settled.
    task automatic press(input int d, input int lane, input int off, input bit hit);
        offset_a[d] = 4'(off);
        if (lane == 0) btn_red_a[d] = 1'b1;
        else btn_blue_a[d] = 1'b1;
        if (hit) begin
            if (lane == 0) expect_event(d, 7, win_judge(d, off), 0);
            else expect_event(d, 7, 0, win_judge(d, off));
        end
        tick(10);
        btn_red_a[d]  = 1'b0;
        btn_blue_a[d] = 1'b0;
        tick(8);
    endtask

    // Offset wraps 15 -> 0; optional misses are judged one cycle later.
    task automatic do_step(input int d, input bit miss_r, input bit miss_b);
        offset_a[d] = 4'd15;
        tick(1);
        offset_a[d] = 4'd0;
        if (miss_r || miss_b) expect_event(d, 1, miss_r ? 3 : 0, miss_b ? 3 : 0);
        tick(3);
    endtask

    // Red press pulse timed to land in the same cycle as a step.
    task automatic same_cycle(input int d, input bit blue_miss);
        offset_a[d]  = 4'd3;
        btn_red_a[d] = 1'b1;
        expect_event(d, 7, win_judge(d, 0), blue_miss ? 3 : 0);
        tick(5);
        offset_a[d] = 4'd15;
        tick(1);
        offset_a[d] = 4'd0;
        tick(4);
        btn_red_a[d] = 1'b0;
        tick(8);
    endtask

    task automatic check_zero(input int d);
        check_eq($sformatf("rst_judge_r%0d", d), 32'(judge_r_a[d]), 32'd0);
        check_eq($sformatf("rst_judge_b%0d", d), 32'(judge_b_a[d]), 32'd0);
        check_eq($sformatf("rst_score%0d", d),   32'(score_a[d]),   32'd0);
        check_eq($sformatf("rst_combo%0d", d),   32'(combo_a[d]),   32'd0);
        check_eq($sformatf("rst_max%0d", d),     32'(max_a[d]),     32'd0);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_score[d] = 0;
            exp_combo[d] = 0;
            exp_max[d]   = 0;
        end
    endtask

    // Scoreboard monitor: every nonzero judgement must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (judge_r_a[d] != 2'd0 || judge_b_a[d] != 2'd0) begin
                    if (sb_q.size() == 0) begin
                        check_eq("spurious_judge", 32'({judge_r_a[d], judge_b_a[d]}), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("judge_dut",   32'(d),            32'(e.d));
                        check_eq("judge_cycle", 32'(cyc),          32'(e.cyc));
                        check_eq("judge_r",     32'(judge_r_a[d]), 32'(e.jr));
                        check_eq("judge_b",     32'(judge_b_a[d]), 32'(e.jb));
                        check_eq("score",       32'(score_a[d]),   32'(e.sc));
                        check_eq("combo",       32'(combo_a[d]),   32'(e.cb));
                        check_eq("max_combo",   32'(max_a[d]),     32'(e.mx));
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            note_r_a[d]   = 10'd0;
            note_b_a[d]   = 10'd0;
            offset_a[d]   = 4'd0;
            finish_a[d]   = 1'b0;
            btn_red_a[d]  = 1'b0;
            btn_blue_a[d] = 1'b0;
        end
        model_reset();
        tick(3);
        @(negedge clk);
        check_zero(0);
        check_zero(1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);

        // Glitch shorter than the debounce window, then a real hold at offset 8.
        note_r_a[0]  = 10'd1;
        offset_a[0]  = 4'd8;
        btn_red_a[0] = 1'b1;
        tick(3);
        btn_red_a[0] = 1'b0;
        tick(3);
        press(0, 0, 8, 1'b1);
        do_step(0, 1'b0, 1'b0);

        // Window edges on fresh notes: good, perfect, perfect, good.
        press(0, 0, 5, 1'b1);
        do_step(0, 1'b0, 1'b0);
        press(0, 0, 6, 1'b1);
        do_step(0, 1'b0, 1'b0);
        press(0, 0, 10, 1'b1);
        do_step(0, 1'b0, 1'b0);
        press(0, 0, 11, 1'b1);
        do_step(0, 1'b0, 1'b0);

        // Unpressed red note scrolls past: miss, combo back to 0, max stays.
        do_step(0, 1'b1, 1'b0);

        // Press in the step cycle: good against the outgoing note, no miss.
        same_cycle(0, 1'b0);

        // Second press on an already consumed note is ignored.
        press(0, 0, 8, 1'b1);
        press(0, 0, 8, 1'b0);
        do_step(0, 1'b0, 1'b0);

        // Red hit and blue miss in one cycle.
        note_b_a[0] = 10'd1;
        same_cycle(0, 1'b1);
        note_b_a[0] = 10'd0;

        // Finish freezes judging and scoring.
        finish_a[0] = 1'b1;
        press(0, 0, 8, 1'b0);
        do_step(0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("finish_score", 32'(score_a[0]), 32'(exp_score[0]));
        check_eq("finish_combo", 32'(combo_a[0]), 32'(exp_combo[0]));
        check_eq("finish_max",   32'(max_a[0]),   32'(exp_max[0]));
        @(posedge clk);
        #1;
        finish_a[0] = 1'b0;

        // Reset in the middle of a held press discards it.
        offset_a[0]  = 4'd8;
        btn_red_a[0] = 1'b1;
        tick(3);
        rst          = 1'b1;
        btn_red_a[0] = 1'b0;
        tick(1);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_zero(0);
        tick(12);
        press(0, 0, 8, 1'b1);
        do_step(0, 1'b0, 1'b0);

        // Saturation instance: 32767 + 32767 = 65534, then a perfect clamps.
        note_r_a[1] = 10'd1;
        press(1, 0, 8, 1'b1);
        do_step(1, 1'b0, 1'b0);
        press(1, 0, 8, 1'b1);
        do_step(1, 1'b0, 1'b0);
        note_b_a[1] = 10'd1;
        same_cycle(1, 1'b1);
        note_b_a[1] = 10'd0;

        tick(5);
        check_eq("pending_expect", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
